// File: rtl/exec_pkg.sv
// Shared definitions for the execute/writeback stage: widths, opcode encoding
// and the helper that tells whether an opcode reads its second source.
package exec_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL1 = 3'd5,
        OP_SHR1 = 3'd6,
        OP_MOV  = 3'd7
    } op_e;

    // Shifts and MOV ignore rs1, so it must never raise a hazard for them.
    function automatic logic uses_rs1(input op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational 8-bit ALU: result and carry/borrow/shifted-out bit per opcode.
module exec_alu
    import exec_pkg::*;
(
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {carry, result} = {1'b0, a} - {1'b0, b};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL1: {carry, result} = {a, 1'b0};
            OP_SHR1: begin
                result = {1'b0, a[DATA_W-1:1]};
                carry  = a[0];
            end
            OP_MOV:  result = a;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/exec_wb_stage.sv
// Execute/writeback stage: E (operands) -> W (result) -> register file write.
// Define FORWARD_EN to resolve RAW hazards by forwarding instead of stalling.
module exec_wb_stage
    import exec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_rs0,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rd,
    output logic [ADDR_W-1:0] raddr0,
    output logic [ADDR_W-1:0] raddr1,
    input  logic [DATA_W-1:0] rdata0,
    input  logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              wren,
    output logic              flag_z,
    output logic              flag_c
);

    logic              e_valid_q, e_valid_d;
    op_e               e_op_q, e_op_d;
    logic [ADDR_W-1:0] e_rd_q, e_rd_d;
    logic [DATA_W-1:0] e_a_q, e_a_d;
    logic [DATA_W-1:0] e_b_q, e_b_d;

    logic              w_valid_q, w_valid_d;
    logic [ADDR_W-1:0] w_rd_q, w_rd_d;
    logic [DATA_W-1:0] w_result_q, w_result_d;
    logic              w_carry_q, w_carry_d;

    logic              flag_z_q, flag_z_d;
    logic              flag_c_q, flag_c_d;

    op_e               in_op_e;
    logic              haz0_e, haz0_w, haz1_e, haz1_w;
    logic              accept;
    logic [DATA_W-1:0] opnd_a, opnd_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    exec_alu u_alu (
        .op     (e_op_q),
        .a      (e_a_q),
        .b      (e_b_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    assign raddr0 = in_rs0;
    assign raddr1 = in_rs1;
    assign waddr  = w_rd_q;
    assign wdata  = w_result_q;
    assign wren   = w_valid_q;

    always_comb begin
        in_op_e = op_e'(in_op);
        haz0_e  = e_valid_q && (in_rs0 == e_rd_q);
        haz0_w  = w_valid_q && (in_rs0 == w_rd_q);
        haz1_e  = uses_rs1(in_op_e) && e_valid_q && (in_rs1 == e_rd_q);
        haz1_w  = uses_rs1(in_op_e) && w_valid_q && (in_rs1 == w_rd_q);
`ifdef FORWARD_EN
        // E holds the youngest in-flight value, so it beats W.
        in_ready = 1'b1;
        opnd_a   = haz0_e ? alu_result : (haz0_w ? w_result_q : rdata0);
        opnd_b   = haz1_e ? alu_result : (haz1_w ? w_result_q : rdata1);
`else
        in_ready = !(haz0_e || haz0_w || haz1_e || haz1_w);
        opnd_a   = rdata0;
        opnd_b   = rdata1;
`endif
        accept = in_valid && in_ready;
    end

    always_comb begin
        e_valid_d  = accept;
        e_op_d     = e_op_q;
        e_rd_d     = e_rd_q;
        e_a_d      = e_a_q;
        e_b_d      = e_b_q;
        w_valid_d  = e_valid_q;
        w_rd_d     = w_rd_q;
        w_result_d = w_result_q;
        w_carry_d  = w_carry_q;
        if (accept) begin
            e_op_d = in_op_e;
            e_rd_d = in_rd;
            e_a_d  = opnd_a;
            e_b_d  = opnd_b;
        end
        if (e_valid_q) begin
            w_rd_d     = e_rd_q;
            w_result_d = alu_result;
            w_carry_d  = alu_carry;
        end
        // Flags show the retiring result during wren and hold it afterwards.
        flag_z_d = w_valid_q ? (w_result_q == '0) : flag_z_q;
        flag_c_d = w_valid_q ? w_carry_q : flag_c_q;
        flag_z   = flag_z_d;
        flag_c   = flag_c_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid_q  <= 1'b0;
            e_op_q     <= OP_ADD;
            e_rd_q     <= '0;
            e_a_q      <= '0;
            e_b_q      <= '0;
            w_valid_q  <= 1'b0;
            w_rd_q     <= '0;
            w_result_q <= '0;
            w_carry_q  <= 1'b0;
            flag_z_q   <= 1'b0;
            flag_c_q   <= 1'b0;
        end else begin
            e_valid_q  <= e_valid_d;
            e_op_q     <= e_op_d;
            e_rd_q     <= e_rd_d;
            e_a_q      <= e_a_d;
            e_b_q      <= e_b_d;
            w_valid_q  <= w_valid_d;
            w_rd_q     <= w_rd_d;
            w_result_q <= w_result_d;
            w_carry_q  <= w_carry_d;
            flag_z_q   <= flag_z_d;
            flag_c_q   <= flag_c_d;
        end
    end

endmodule
